mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one AXI-Lite-style memory port (128-bit line reads and writes, 32-bit write response) between two cache masters: M0 = instruction cache, M1 = data cache.
- Sits between the cache controllers and the memory model or system bus.
- Holds exactly one transaction in flight at a time, with round-robin fairness between the masters.
- Grant is held from the address phase until the read data or write response completes.

Parameters:
ADDR_W, 32, address width on all readAddr/writeAddr channels
DATA_W, 128, cache-line data width
STRB_W, 16, write strobe width (DATA_W/8)
RESP_W, 32, writeResp_msg width

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
m0_/m1_readAddr_{addr,valid} / _ready  input / output  ADDR_W+1 / 1  read address channel from each master
m0_/m1_readData_{data,valid} / _ready  output / input  DATA_W+1 / 1  read data channel to each master
m0_/m1_writeAddr_{addr,valid} / _ready  input / output  ADDR_W+1 / 1  write address channel from each master
m0_/m1_writeData_{data,strb,valid} / _ready  input / output  DATA_W+STRB_W+1 / 1  write data channel from each master
m0_/m1_writeResp_{msg,valid} / _ready  output / input  RESP_W+1 / 1  write response channel to each master
s_readAddr_*, s_readData_*, s_writeAddr_*, s_writeData_*, s_writeResp_*  mirrored directions  same widths  slave-side channels
grant  output  2  one-hot current owner (bit0 = M0, bit1 = M1); 0 when idle
busy  output  1  1 while in any state other than IDLE

Behaviour:
- Request definition:
  - Master i requests a read when its readAddr_valid = 1.
  - Master i requests a write when its writeAddr_valid = 1.
  - If one master asserts both, the write is serviced first.
- State register: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Additional registers: gnt_id, last_id, aw_done, w_done.
- Reset (rst = 0, asynchronous):
  - state = IDLE, grant = 0, busy = 0, aw_done = w_done = 0.
  - last_id = 1, so M0 wins the first tie.
  - All slave-side valid/ready outputs and all master-side ready/valid outputs are 0.
  - Data, addr, strb and msg outputs are 0.
  - Reset mid-transaction aborts the transaction silently; no completion is delivered.
- IDLE:
  - All valids and readies on both sides are 0.
  - If exactly one master requests, register gnt_id to that master.
  - If both request, register gnt_id = ~last_id.
  - Next state is WR_REQ for a write, otherwise RD_ADDR.
  - Arbitration latency is 1 cycle: the slave-side valid rises the cycle after the request is first seen in IDLE.
- Routing while granted:
  - All slave inputs are driven combinationally from master gnt_id.
  - The granted master's ready/response signals are driven from the slave.
  - The non-granted master sees all of its ready and valid outputs at 0 and its data/msg outputs at 0, and stays stalled.
- RD_ADDR: forward readAddr. On s_readAddr_valid & s_readAddr_ready, go to RD_DATA.
- RD_DATA: forward readData. On s_readData_valid & m_readData_ready, go to IDLE and set last_id = gnt_id.
- WR_REQ:
  - Forward writeAddr and writeData independently.
  - s_writeAddr_valid = m_writeAddr_valid & ~aw_done. The master's writeAddr_ready is gated the same way.
  - s_writeData_valid and the master's writeData_ready are gated identically by w_done.
  - Each handshake sets its done flag.
  - Go to WR_RESP when both handshakes have completed. Same-cycle completion of both handshakes is allowed and goes to WR_RESP on the next edge.
- WR_RESP:
  - Forward writeResp.
  - On handshake, go to IDLE, set last_id = gnt_id, and clear aw_done and w_done.
- Back-to-back: at least one IDLE cycle between transactions. A master re-requesting while the other is waiting loses the tie.
- No timeout. A master dropping valid after grant is a protocol violation; the grant is held until completion.
- grant = one-hot of gnt_id when state ≠ IDLE.

Test Plan:
- Single read, no contention:
  - Stimulus: M1 read, addr 0x0000_1230; slave ready immediately; data 0x0123…CDEF returned 2 cycles later.
  - Response: grant = 2'b10 the cycle after the request; s_readAddr_addr = 0x1230; M1 receives the exact 128-bit data; M0 readies stay 0; busy falls 1 cycle after the data handshake.
- Simultaneous reads after reset:
  - Stimulus: M0 and M1 assert read in the same cycle.
  - Response: M0 is served first (grant 2'b01), then M1 (grant 2'b10); exactly one IDLE cycle between the two.
- Round-robin under saturation:
  - Stimulus: both masters continuously request 4 reads each.
  - Response: grants alternate 01, 10, 01, 10, …; no master is served twice in a row while the other is waiting.
- Write with skewed channels:
  - Stimulus: M1 write, addr 0x0040, strb 0x000F; slave accepts data 2 cycles before the address.
  - Response: data valid is deasserted after the data handshake; address still completes; state goes to WR_RESP; M1 receives writeResp_msg 0x0000_0000.
- Write priority within a master:
  - Stimulus: M0 asserts read and write simultaneously.
  - Response: the write is performed first; the read is serviced in the next grant.
- Mid-transaction reset:
  - Stimulus: rst = 0 while in RD_DATA.
  - Response: immediately (asynchronously) grant = 0, busy = 0, all valid/ready outputs 0; after release, the first tie goes to M0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one AXI-Lite-style memory port between two cache masters
//   (M0 = instruction cache, M1 = data cache). One transaction is in flight
//   at a time; the grant is held from the address phase until the read data
//   or write response handshake completes. Ties go round-robin.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   m{0,1}_readAddr_*             read address channel from each master
//   m{0,1}_readData_*             read data channel to each master
//   m{0,1}_writeAddr_*            write address channel from each master
//   m{0,1}_writeData_*            write data channel from each master
//   m{0,1}_writeResp_*            write response channel to each master
//   s_*                           slave-side mirror of the five channels
//   grant                         one-hot owner (bit0 = M0, bit1 = M1), 0 when idle
//   busy                          1 whenever a transaction is in progress
//
// state   | meaning
// IDLE    | no owner, all handshakes blocked, arbitrating
// RD_ADDR | forwarding the owner's read address
// RD_DATA | forwarding read data back to the owner
// WR_REQ  | forwarding write address and data, each tracked by a done flag
// WR_RESP | forwarding the write response back to the owner

module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int STRB_W = 16,
  parameter int RESP_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] m0_readAddr_addr,
  input  logic              m0_readAddr_valid,
  output logic              m0_readAddr_ready,
  output logic [DATA_W-1:0] m0_readData_data,
  output logic              m0_readData_valid,
  input  logic              m0_readData_ready,
  input  logic [ADDR_W-1:0] m0_writeAddr_addr,
  input  logic              m0_writeAddr_valid,
  output logic              m0_writeAddr_ready,
  input  logic [DATA_W-1:0] m0_writeData_data,
  input  logic [STRB_W-1:0] m0_writeData_strb,
  input  logic              m0_writeData_valid,
  output logic              m0_writeData_ready,
  output logic [RESP_W-1:0] m0_writeResp_msg,
  output logic              m0_writeResp_valid,
  input  logic              m0_writeResp_ready,

  input  logic [ADDR_W-1:0] m1_readAddr_addr,
  input  logic              m1_readAddr_valid,
  output logic              m1_readAddr_ready,
  output logic [DATA_W-1:0] m1_readData_data,
  output logic              m1_readData_valid,
  input  logic              m1_readData_ready,
  input  logic [ADDR_W-1:0] m1_writeAddr_addr,
  input  logic              m1_writeAddr_valid,
  output logic              m1_writeAddr_ready,
  input  logic [DATA_W-1:0] m1_writeData_data,
  input  logic [STRB_W-1:0] m1_writeData_strb,
  input  logic              m1_writeData_valid,
  output logic              m1_writeData_ready,
  output logic [RESP_W-1:0] m1_writeResp_msg,
  output logic              m1_writeResp_valid,
  input  logic              m1_writeResp_ready,

  output logic [ADDR_W-1:0] s_readAddr_addr,
  output logic              s_readAddr_valid,
  input  logic              s_readAddr_ready,
  input  logic [DATA_W-1:0] s_readData_data,
  input  logic              s_readData_valid,
  output logic              s_readData_ready,
  output logic [ADDR_W-1:0] s_writeAddr_addr,
  output logic              s_writeAddr_valid,
  input  logic              s_writeAddr_ready,
  output logic [DATA_W-1:0] s_writeData_data,
  output logic [STRB_W-1:0] s_writeData_strb,
  output logic              s_writeData_valid,
  input  logic              s_writeData_ready,
  input  logic [RESP_W-1:0] s_writeResp_msg,
  input  logic              s_writeResp_valid,
  output logic              s_writeResp_ready,

  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t r_state, w_state_nxt;
  logic   r_gnt_id, w_gnt_id_nxt;
  logic   r_last_id, w_last_id_nxt;
  logic   r_aw_done, w_aw_done_nxt;
  logic   r_w_done, w_w_done_nxt;

  // Owner's inputs, selected by gnt_id
  logic [ADDR_W-1:0] w_ra_addr, w_wa_addr;
  logic [DATA_W-1:0] w_wd_data;
  logic [STRB_W-1:0] w_wd_strb;
  logic              w_ra_valid, w_rd_ready, w_wa_valid, w_wd_valid, w_wr_ready;

  // Signals headed back to the owner, demuxed below
  logic              w_ra_ready, w_rd_valid, w_wa_ready, w_wd_ready, w_wr_valid;
  logic [DATA_W-1:0] w_rd_data;
  logic [RESP_W-1:0] w_wr_msg;

  logic w_req0, w_req1, w_sel, w_aw_hs, w_wd_hs;

  assign w_ra_addr  = r_gnt_id ? m1_readAddr_addr   : m0_readAddr_addr;
  assign w_ra_valid = r_gnt_id ? m1_readAddr_valid  : m0_readAddr_valid;
  assign w_rd_ready = r_gnt_id ? m1_readData_ready  : m0_readData_ready;
  assign w_wa_addr  = r_gnt_id ? m1_writeAddr_addr  : m0_writeAddr_addr;
  assign w_wa_valid = r_gnt_id ? m1_writeAddr_valid : m0_writeAddr_valid;
  assign w_wd_data  = r_gnt_id ? m1_writeData_data  : m0_writeData_data;
  assign w_wd_strb  = r_gnt_id ? m1_writeData_strb  : m0_writeData_strb;
  assign w_wd_valid = r_gnt_id ? m1_writeData_valid : m0_writeData_valid;
  assign w_wr_ready = r_gnt_id ? m1_writeResp_ready : m0_writeResp_ready;

  assign w_req0 = m0_readAddr_valid | m0_writeAddr_valid;
  assign w_req1 = m1_readAddr_valid | m1_writeAddr_valid;
  // On a tie the master that was not served last wins
  assign w_sel  = (w_req0 & w_req1) ? ~r_last_id : w_req1;

  // Done flags block a channel once its handshake has happened
  assign w_aw_hs = (r_state == WR_REQ) & w_wa_valid & ~r_aw_done & s_writeAddr_ready;
  assign w_wd_hs = (r_state == WR_REQ) & w_wd_valid & ~r_w_done  & s_writeData_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_gnt_id  <= 1'b0;
      r_last_id <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_last_id <= w_last_id_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_gnt_id_nxt      = r_gnt_id;
    w_last_id_nxt     = r_last_id;
    w_aw_done_nxt     = r_aw_done;
    w_w_done_nxt      = r_w_done;
    s_readAddr_addr   = '0;
    s_readAddr_valid  = 1'b0;
    s_readData_ready  = 1'b0;
    s_writeAddr_addr  = '0;
    s_writeAddr_valid = 1'b0;
    s_writeData_data  = '0;
    s_writeData_strb  = '0;
    s_writeData_valid = 1'b0;
    s_writeResp_ready = 1'b0;
    w_ra_ready        = 1'b0;
    w_rd_data         = '0;
    w_rd_valid        = 1'b0;
    w_wa_ready        = 1'b0;
    w_wd_ready        = 1'b0;
    w_wr_msg          = '0;
    w_wr_valid        = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_req0 | w_req1) begin
          w_gnt_id_nxt = w_sel;
          // A write from the chosen master takes precedence over its read
          w_state_nxt  = (w_sel ? m1_writeAddr_valid : m0_writeAddr_valid) ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        s_readAddr_addr  = w_ra_addr;
        s_readAddr_valid = w_ra_valid;
        w_ra_ready       = s_readAddr_ready;
        if (w_ra_valid & s_readAddr_ready) w_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        w_rd_data        = s_readData_data;
        w_rd_valid       = s_readData_valid;
        s_readData_ready = w_rd_ready;
        if (s_readData_valid & w_rd_ready) begin
          w_state_nxt   = IDLE;
          w_last_id_nxt = r_gnt_id;
        end
      end
      WR_REQ: begin
        s_writeAddr_addr  = w_wa_addr;
        s_writeAddr_valid = w_wa_valid & ~r_aw_done;
        w_wa_ready        = s_writeAddr_ready & ~r_aw_done;
        s_writeData_data  = w_wd_data;
        s_writeData_strb  = w_wd_strb;
        s_writeData_valid = w_wd_valid & ~r_w_done;
        w_wd_ready        = s_writeData_ready & ~r_w_done;
        w_aw_done_nxt     = r_aw_done | w_aw_hs;
        w_w_done_nxt      = r_w_done | w_wd_hs;
        if (w_aw_done_nxt & w_w_done_nxt) w_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        w_wr_msg          = s_writeResp_msg;
        w_wr_valid        = s_writeResp_valid;
        s_writeResp_ready = w_wr_ready;
        if (s_writeResp_valid & w_wr_ready) begin
          w_state_nxt   = IDLE;
          w_last_id_nxt = r_gnt_id;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The non-granted master sees only zeros
  assign m0_readAddr_ready  = ~r_gnt_id & w_ra_ready;
  assign m0_readData_data   = r_gnt_id ? '0 : w_rd_data;
  assign m0_readData_valid  = ~r_gnt_id & w_rd_valid;
  assign m0_writeAddr_ready = ~r_gnt_id & w_wa_ready;
  assign m0_writeData_ready = ~r_gnt_id & w_wd_ready;
  assign m0_writeResp_msg   = r_gnt_id ? '0 : w_wr_msg;
  assign m0_writeResp_valid = ~r_gnt_id & w_wr_valid;

  assign m1_readAddr_ready  = r_gnt_id & w_ra_ready;
  assign m1_readData_data   = r_gnt_id ? w_rd_data : '0;
  assign m1_readData_valid  = r_gnt_id & w_rd_valid;
  assign m1_writeAddr_ready = r_gnt_id & w_wa_ready;
  assign m1_writeData_ready = r_gnt_id & w_wd_ready;
  assign m1_writeResp_msg   = r_gnt_id ? w_wr_msg : '0;
  assign m1_writeResp_valid = r_gnt_id & w_wr_valid;

  assign busy  = (r_state != IDLE);
  assign grant = busy ? (r_gnt_id ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, single read, tie and
// round-robin reads, skewed write, write-before-read, mid-transaction reset.

module tb_mem_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst;

  logic [31:0]  m0_readAddr_addr, m1_readAddr_addr;
  logic         m0_readAddr_valid, m1_readAddr_valid;
  logic         m0_readAddr_ready, m1_readAddr_ready;
  logic [127:0] m0_readData_data, m1_readData_data;
  logic         m0_readData_valid, m1_readData_valid;
  logic         m0_readData_ready, m1_readData_ready;
  logic [31:0]  m0_writeAddr_addr, m1_writeAddr_addr;
  logic         m0_writeAddr_valid, m1_writeAddr_valid;
  logic         m0_writeAddr_ready, m1_writeAddr_ready;
  logic [127:0] m0_writeData_data, m1_writeData_data;
  logic [15:0]  m0_writeData_strb, m1_writeData_strb;
  logic         m0_writeData_valid, m1_writeData_valid;
  logic         m0_writeData_ready, m1_writeData_ready;
  logic [31:0]  m0_writeResp_msg, m1_writeResp_msg;
  logic         m0_writeResp_valid, m1_writeResp_valid;
  logic         m0_writeResp_ready, m1_writeResp_ready;

  logic [31:0]  s_readAddr_addr;
  logic         s_readAddr_valid, s_readAddr_ready;
  logic [127:0] s_readData_data;
  logic         s_readData_valid, s_readData_ready;
  logic [31:0]  s_writeAddr_addr;
  logic         s_writeAddr_valid, s_writeAddr_ready;
  logic [127:0] s_writeData_data;
  logic [15:0]  s_writeData_strb;
  logic         s_writeData_valid, s_writeData_ready;
  logic [31:0]  s_writeResp_msg;
  logic         s_writeResp_valid, s_writeResp_ready;

  logic [1:0]   grant;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] RD_DATA0 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] WR_DATA0 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_readAddr_addr(m0_readAddr_addr), .m0_readAddr_valid(m0_readAddr_valid), .m0_readAddr_ready(m0_readAddr_ready),
    .m0_readData_data(m0_readData_data), .m0_readData_valid(m0_readData_valid), .m0_readData_ready(m0_readData_ready),
    .m0_writeAddr_addr(m0_writeAddr_addr), .m0_writeAddr_valid(m0_writeAddr_valid), .m0_writeAddr_ready(m0_writeAddr_ready),
    .m0_writeData_data(m0_writeData_data), .m0_writeData_strb(m0_writeData_strb), .m0_writeData_valid(m0_writeData_valid),
    .m0_writeData_ready(m0_writeData_ready),
    .m0_writeResp_msg(m0_writeResp_msg), .m0_writeResp_valid(m0_writeResp_valid), .m0_writeResp_ready(m0_writeResp_ready),
    .m1_readAddr_addr(m1_readAddr_addr), .m1_readAddr_valid(m1_readAddr_valid), .m1_readAddr_ready(m1_readAddr_ready),
    .m1_readData_data(m1_readData_data), .m1_readData_valid(m1_readData_valid), .m1_readData_ready(m1_readData_ready),
    .m1_writeAddr_addr(m1_writeAddr_addr), .m1_writeAddr_valid(m1_writeAddr_valid), .m1_writeAddr_ready(m1_writeAddr_ready),
    .m1_writeData_data(m1_writeData_data), .m1_writeData_strb(m1_writeData_strb), .m1_writeData_valid(m1_writeData_valid),
    .m1_writeData_ready(m1_writeData_ready),
    .m1_writeResp_msg(m1_writeResp_msg), .m1_writeResp_valid(m1_writeResp_valid), .m1_writeResp_ready(m1_writeResp_ready),
    .s_readAddr_addr(s_readAddr_addr), .s_readAddr_valid(s_readAddr_valid), .s_readAddr_ready(s_readAddr_ready),
    .s_readData_data(s_readData_data), .s_readData_valid(s_readData_valid), .s_readData_ready(s_readData_ready),
    .s_writeAddr_addr(s_writeAddr_addr), .s_writeAddr_valid(s_writeAddr_valid), .s_writeAddr_ready(s_writeAddr_ready),
    .s_writeData_data(s_writeData_data), .s_writeData_strb(s_writeData_strb), .s_writeData_valid(s_writeData_valid),
    .s_writeData_ready(s_writeData_ready),
    .s_writeResp_msg(s_writeResp_msg), .s_writeResp_valid(s_writeResp_valid), .s_writeResp_ready(s_writeResp_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_readAddr_addr = '0;  m0_readAddr_valid = 1'b0;  m0_readData_ready = 1'b0;
    m0_writeAddr_addr = '0; m0_writeAddr_valid = 1'b0; m0_writeData_data = '0;
    m0_writeData_strb = '0; m0_writeData_valid = 1'b0; m0_writeResp_ready = 1'b0;
    m1_readAddr_addr = '0;  m1_readAddr_valid = 1'b0;  m1_readData_ready = 1'b0;
    m1_writeAddr_addr = '0; m1_writeAddr_valid = 1'b0; m1_writeData_data = '0;
    m1_writeData_strb = '0; m1_writeData_valid = 1'b0; m1_writeResp_ready = 1'b0;
    s_readAddr_ready = 1'b0;  s_readData_data = '0;   s_readData_valid = 1'b0;
    s_writeAddr_ready = 1'b0; s_writeData_ready = 1'b0;
    s_writeResp_msg = '0;     s_writeResp_valid = 1'b0;
  endtask

  initial begin
    logic [1:0]   exp_gnt;
    logic [31:0]  exp_addr;
    logic [127:0] got_data;
    logic         got_valid, other_valid;

    // ---- reset ----
    rst = 1'b0;
    clear_inputs();
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_ra_valid", s_readAddr_valid, 1'b0);
    chk("rst_s_rd_ready", s_readData_ready, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // ---- single read from M1, data two cycles after address ----
    m1_readAddr_addr = 32'h0000_1230; m1_readAddr_valid = 1'b1;
    m1_readData_ready = 1'b1; s_readAddr_ready = 1'b1;
    #1;
    chk("rd1_idle_valid", s_readAddr_valid, 1'b0);
    chk("rd1_idle_grant", grant, 2'b00);
    tick();
    chk("rd1_grant", grant, 2'b10);
    chk("rd1_busy", busy, 1'b1);
    chk("rd1_s_addr", s_readAddr_addr, 32'h0000_1230);
    chk("rd1_s_valid", s_readAddr_valid, 1'b1);
    chk("rd1_m1_ready", m1_readAddr_ready, 1'b1);
    chk("rd1_m0_ready", m0_readAddr_ready, 1'b0);
    tick();
    m1_readAddr_valid = 1'b0;
    #1;
    chk("rd1_wait_valid", m1_readData_valid, 1'b0);
    chk("rd1_wait_busy", busy, 1'b1);
    tick();
    s_readData_valid = 1'b1; s_readData_data = RD_DATA0;
    #1;
    chk("rd1_m1_valid", m1_readData_valid, 1'b1);
    chk("rd1_m1_data", m1_readData_data, RD_DATA0);
    chk("rd1_m0_valid", m0_readData_valid, 1'b0);
    chk("rd1_m0_data", m0_readData_data, 128'h0);
    chk("rd1_s_rd_ready", s_readData_ready, 1'b1);
    tick();
    clear_inputs();
    #1;
    chk("rd1_done_busy", busy, 1'b0);
    chk("rd1_done_grant", grant, 2'b00);

    // ---- tie then saturation: both masters request reads continuously ----
    m0_readAddr_addr = 32'h0000_A000; m0_readAddr_valid = 1'b1; m0_readData_ready = 1'b1;
    m1_readAddr_addr = 32'h0000_B000; m1_readAddr_valid = 1'b1; m1_readData_ready = 1'b1;
    s_readAddr_ready = 1'b1; s_readData_valid = 1'b1; s_readData_data = RD_DATA0;
    for (int k = 0; k < 8; k++) begin
      exp_gnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 32'h0000_A000 : 32'h0000_B000;
      #1;
      chk($sformatf("sat%0d_idle_busy", k), busy, 1'b0);
      tick();
      chk($sformatf("sat%0d_grant", k), grant, exp_gnt);
      chk($sformatf("sat%0d_addr", k), s_readAddr_addr, exp_addr);
      tick();
      got_valid   = (k % 2 == 0) ? m0_readData_valid : m1_readData_valid;
      other_valid = (k % 2 == 0) ? m1_readData_valid : m0_readData_valid;
      got_data    = (k % 2 == 0) ? m0_readData_data  : m1_readData_data;
      chk($sformatf("sat%0d_rd_valid", k), got_valid, 1'b1);
      chk($sformatf("sat%0d_other_valid", k), other_valid, 1'b0);
      chk($sformatf("sat%0d_rd_data", k), got_data, RD_DATA0);
      tick();
      if (k == 7) clear_inputs();
    end

    // ---- M1 write, data accepted two cycles before address ----
    m1_writeAddr_addr = 32'h0000_0040; m1_writeAddr_valid = 1'b1;
    m1_writeData_data = WR_DATA0; m1_writeData_strb = 16'h000F; m1_writeData_valid = 1'b1;
    s_writeData_ready = 1'b1; s_writeAddr_ready = 1'b0;
    #1;
    chk("wr_idle_valid", s_writeAddr_valid, 1'b0);
    tick();
    chk("wr_grant", grant, 2'b10);
    chk("wr_s_aw_valid", s_writeAddr_valid, 1'b1);
    chk("wr_s_aw_addr", s_writeAddr_addr, 32'h0000_0040);
    chk("wr_s_w_valid", s_writeData_valid, 1'b1);
    chk("wr_s_w_strb", s_writeData_strb, 16'h000F);
    chk("wr_s_w_data", s_writeData_data, WR_DATA0);
    chk("wr_m1_w_ready", m1_writeData_ready, 1'b1);
    chk("wr_m1_aw_ready", m1_writeAddr_ready, 1'b0);
    tick();
    chk("wr_w_dropped", s_writeData_valid, 1'b0);
    chk("wr_m1_w_ready_off", m1_writeData_ready, 1'b0);
    chk("wr_aw_still", s_writeAddr_valid, 1'b1);
    tick();
    chk("wr_wait_busy", busy, 1'b1);
    chk("wr_w_still_off", s_writeData_valid, 1'b0);
    s_writeAddr_ready = 1'b1;
    #1;
    chk("wr_m1_aw_ready_on", m1_writeAddr_ready, 1'b1);
    tick();
    m1_writeAddr_valid = 1'b0; m1_writeData_valid = 1'b0;
    s_writeAddr_ready = 1'b0; s_writeData_ready = 1'b0;
    s_writeResp_valid = 1'b1; s_writeResp_msg = 32'h0000_0000; m1_writeResp_ready = 1'b1;
    #1;
    chk("wr_resp_aw_off", s_writeAddr_valid, 1'b0);
    chk("wr_resp_valid", m1_writeResp_valid, 1'b1);
    chk("wr_resp_msg", m1_writeResp_msg, 32'h0000_0000);
    chk("wr_resp_s_ready", s_writeResp_ready, 1'b1);
    chk("wr_resp_m0_valid", m0_writeResp_valid, 1'b0);
    tick();
    clear_inputs();
    #1;
    chk("wr_done_busy", busy, 1'b0);

    // ---- M0 read and write together: write first, read next grant ----
    m0_readAddr_addr = 32'h0000_0C00; m0_readAddr_valid = 1'b1;
    m0_writeAddr_addr = 32'h0000_0D00; m0_writeAddr_valid = 1'b1;
    m0_writeData_data = WR_DATA0; m0_writeData_strb = 16'hFFFF; m0_writeData_valid = 1'b1;
    s_writeAddr_ready = 1'b1; s_writeData_ready = 1'b1; s_readAddr_ready = 1'b1;
    tick();
    chk("prio_grant", grant, 2'b01);
    chk("prio_s_aw_valid", s_writeAddr_valid, 1'b1);
    chk("prio_s_ra_valid", s_readAddr_valid, 1'b0);
    chk("prio_m0_aw_ready", m0_writeAddr_ready, 1'b1);
    tick();
    m0_writeAddr_valid = 1'b0; m0_writeData_valid = 1'b0;
    s_writeResp_valid = 1'b1; s_writeResp_msg = 32'h0000_0005; m0_writeResp_ready = 1'b1;
    #1;
    chk("prio_resp_valid", m0_writeResp_valid, 1'b1);
    chk("prio_resp_msg", m0_writeResp_msg, 32'h0000_0005);
    tick();
    s_writeResp_valid = 1'b0; m0_writeResp_ready = 1'b0;
    #1;
    chk("prio_gap_busy", busy, 1'b0);
    tick();
    chk("prio_rd_grant", grant, 2'b01);
    chk("prio_rd_valid", s_readAddr_valid, 1'b1);
    chk("prio_rd_addr", s_readAddr_addr, 32'h0000_0C00);
    tick();
    m0_readAddr_valid = 1'b0; m0_readData_ready = 1'b1;
    #1;
    chk("rst_mid_busy_before", busy, 1'b1);
    chk("rst_mid_s_rd_ready_before", s_readData_ready, 1'b1);

    // ---- asynchronous reset while in RD_DATA ----
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_grant", grant, 2'b00);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_s_rd_ready", s_readData_ready, 1'b0);
    chk("rst_mid_m0_rd_valid", m0_readData_valid, 1'b0);
    s_readData_valid = 1'b1; s_readData_data = RD_DATA0;
    #1;
    chk("rst_mid_no_complete", m0_readData_valid, 1'b0);
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    // last served before reset was M0; reset must hand the tie back to M0
    m0_readAddr_addr = 32'h0000_0E00; m0_readAddr_valid = 1'b1;
    m1_readAddr_addr = 32'h0000_0F00; m1_readAddr_valid = 1'b1;
    tick();
    chk("post_rst_grant", grant, 2'b01);
    chk("post_rst_addr", s_readAddr_addr, 32'h0000_0E00);
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
